eng_pipe_mt: RTL
================

ENG_PIPE_MT -- requirements
Module: eng_pipe_mt

Interface
REQ-001 Parameter CTX_N, default 4, number of hardware contexts (2..16); CTX_W = clog2(CTX_N).
REQ-002 Parameter PC_W, default 16, program-counter width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 arst  input  1  asynchronous, active-high reset.
REQ-005 i_start_vld  input  1  context start request.
REQ-006 i_start_ctx  input  CTX_W  context to start.
REQ-007 i_start_pc  input  PC_W  initial PC of started context.
REQ-008 o_ctx_busy  output  CTX_N  bit i set when context i not IDLE.
REQ-009 o_fa_vld / o_fa_ctx / o_fa_pc  output  1 / CTX_W / PC_W  FA-stage fetch issue (registered).
REQ-010 i_xa_stall  input  1  holds FA and XA stage registers.
REQ-011 i_xa_redirect_vld / i_xa_redirect_pc  input  1 / PC_W  taken branch for instruction in XA.
REQ-012 i_xa_halt  input  1  instruction in XA terminates its context.
REQ-013 o_ca_vld / o_ca_ctx / o_ca_pc  output  1 / CTX_W / PC_W  CA-stage commit (registered).
REQ-014 o_perf_commit_cnt  output  32  committed-instruction count.

Function
REQ-015 Each context SHALL hold state IDLE, READY or INFLIGHT plus a PC_W-bit PC.
REQ-016 i_start_vld on an IDLE context SHALL load i_start_pc and move it to READY next cycle; start on non-IDLE context SHALL be ignored.
REQ-017 When i_xa_stall=0, FA SHALL issue the first READY context at or after the round-robin pointer (wrapping), set it INFLIGHT, and set pointer to chosen+1 mod CTX_N.
REQ-018 No READY context or i_xa_stall=1 SHALL yield o_fa_vld=0 next cycle; pointer unchanged.
REQ-019 At most one instruction per context SHALL be in flight; FA->XA->CA latency is exactly 2 cycles absent stall.
REQ-020 i_xa_stall=1 SHALL freeze FA and XA registers and insert a bubble (o_ca_vld=0) into CA.
REQ-021 On XA advance: next PC = i_xa_redirect_pc if redirect_vld, else PC+1 modulo 2^PC_W (wrap, no flag).
REQ-022 i_xa_halt SHALL take priority over redirect; context goes IDLE in its CA cycle.
REQ-023 Non-halted context SHALL return to READY with next PC in its CA cycle; eligible for fetch the following cycle (single context: one issue per 3 cycles).
REQ-024 Start for a context in the same cycle it commits to IDLE SHALL be ignored.
REQ-025 redirect/halt inputs SHALL be ignored when XA holds no valid instruction.

Reset
REQ-026 arst SHALL immediately clear: all contexts IDLE, PCs 0, pointer 0, o_fa_vld=0, o_ca_vld=0, o_fa_ctx/pc=0, o_ca_ctx/pc=0, o_ctx_busy=0, o_perf_commit_cnt=0.
REQ-027 Reset mid-operation SHALL discard all in-flight instructions with no commit emitted.

Configuration
REQ-028 With ENG_PIPE_PERF_CNT_EN defined, o_perf_commit_cnt SHALL increment by 1 per o_ca_vld cycle, saturating at 0xFFFF_FFFF.
REQ-029 Without ENG_PIPE_PERF_CNT_EN, o_perf_commit_cnt SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-030 Start ctx0 pc=0x0010, no stall -> o_fa_pc 0x0010,0x0011,0x0012 every 3rd cycle; o_ca_pc follows each by 2 cycles.
REQ-031 Start ctx0..3 pcs 0x100/0x200/0x300/0x400 same-cycle staggered -> FA issues ctx order 0,1,2,3,0... one per cycle with no bubbles.
REQ-032 ctx1 pc=0xFFFF, no redirect -> next fetch of ctx1 pc=0x0000.
REQ-033 ctx2 in XA with redirect_vld and pc=0x0ABC, halt=1 same cycle -> ctx2 commits, o_ctx_busy[2]=0, no further ctx2 fetch.
REQ-034 i_xa_stall high 3 cycles with ctx0 in XA -> o_fa_vld=0 and o_ca_vld=0 for 3 cycles, then ctx0 commits with unchanged pc.
REQ-035 arst pulse with 3 contexts in flight -> all outputs 0 immediately, counter 0, no commit after release until new start.

Source files
------------

// File: rtl/eng_pipe_mt_if.sv
// Bus bundle for the multi-context fetch/execute/commit pipeline eng_pipe_mt.
//
// Signals:
//   i_start_vld / i_start_ctx / i_start_pc  - request to start a context at a given PC
//   o_ctx_busy                              - one bit per context, set when not idle
//   o_fa_vld / o_fa_ctx / o_fa_pc           - fetch issued in the FA stage
//   i_xa_stall                              - holds FA and XA, bubbles CA
//   i_xa_redirect_vld / i_xa_redirect_pc    - taken branch for the instruction in XA
//   i_xa_halt                               - instruction in XA ends its context
//   o_ca_vld / o_ca_ctx / o_ca_pc           - commit in the CA stage
//   o_perf_commit_cnt                       - committed-instruction count
//
// Modports: master drives the i_* side (pipeline environment), slave is the pipeline.

interface eng_pipe_mt_if #(
    parameter int unsigned CTX_N = 4,
    parameter int unsigned PC_W  = 16
);
    localparam int unsigned CTX_W = $clog2(CTX_N);

    logic             i_start_vld;
    logic [CTX_W-1:0] i_start_ctx;
    logic [PC_W-1:0]  i_start_pc;
    logic [CTX_N-1:0] o_ctx_busy;
    logic             o_fa_vld;
    logic [CTX_W-1:0] o_fa_ctx;
    logic [PC_W-1:0]  o_fa_pc;
    logic             i_xa_stall;
    logic             i_xa_redirect_vld;
    logic [PC_W-1:0]  i_xa_redirect_pc;
    logic             i_xa_halt;
    logic             o_ca_vld;
    logic [CTX_W-1:0] o_ca_ctx;
    logic [PC_W-1:0]  o_ca_pc;
    logic [31:0]      o_perf_commit_cnt;

    modport master (
        output i_start_vld, i_start_ctx, i_start_pc,
        output i_xa_stall, i_xa_redirect_vld, i_xa_redirect_pc, i_xa_halt,
        input  o_ctx_busy, o_fa_vld, o_fa_ctx, o_fa_pc,
        input  o_ca_vld, o_ca_ctx, o_ca_pc, o_perf_commit_cnt
    );

    modport slave (
        input  i_start_vld, i_start_ctx, i_start_pc,
        input  i_xa_stall, i_xa_redirect_vld, i_xa_redirect_pc, i_xa_halt,
        output o_ctx_busy, o_fa_vld, o_fa_ctx, o_fa_pc,
        output o_ca_vld, o_ca_ctx, o_ca_pc, o_perf_commit_cnt
    );
endinterface

// File: rtl/eng_pipe_mt.sv
// Barrel-style multi-context pipeline: FA (fetch issue) -> XA (execute) -> CA (commit).
// Each context is IDLE, READY or INFLIGHT and owns a PC; at most one instruction per
// context is in the pipe. FA picks READY contexts round-robin.
//
// Ports:
//   clk  - sole clock, rising edge
//   arst - asynchronous active-high reset
//   bus  - eng_pipe_mt_if.slave (start requests, FA issue, XA controls, CA commit, perf count)
//
// Optional feature: define ENG_PIPE_PERF_CNT_EN to build the saturating commit counter;
// without it o_perf_commit_cnt is tied to 0.

module eng_pipe_mt #(
    parameter int unsigned CTX_N = 4,
    parameter int unsigned PC_W  = 16
) (
    input logic         clk,
    input logic         arst,
    eng_pipe_mt_if.slave bus
);
    localparam int unsigned CTX_W = $clog2(CTX_N);

    typedef enum logic [1:0] {StIdle, StReady, StInflight} ctx_st_e;

    ctx_st_e          ctx_st_q [CTX_N];
    logic [PC_W-1:0]  ctx_pc_q [CTX_N];
    logic [CTX_W-1:0] rr_ptr_q;

    // fa_occ_q tracks an instruction sitting in FA; fa_vld_q is only the issue pulse, so
    // an instruction frozen in FA by a stall is not reported as a second issue.
    logic             fa_occ_q;
    logic             fa_vld_q;
    logic [CTX_W-1:0] fa_ctx_q;
    logic [PC_W-1:0]  fa_pc_q;
    logic             xa_vld_q;
    logic [CTX_W-1:0] xa_ctx_q;
    logic [PC_W-1:0]  xa_pc_q;
    logic             ca_vld_q;
    logic [CTX_W-1:0] ca_ctx_q;
    logic [PC_W-1:0]  ca_pc_q;

    logic             pick_vld;
    logic [CTX_W-1:0] pick_ctx;
    logic             issue;
    logic             xa_adv;
    logic [PC_W-1:0]  xa_next_pc;

    function automatic logic [CTX_W-1:0] ctx_wrap(input int unsigned v);
        return CTX_W'(v % CTX_N);
    endfunction

    // First READY context at or after the pointer, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_ctx = '0;
        for (int unsigned k = 0; k < CTX_N; k++) begin
            if (!pick_vld && ctx_st_q[ctx_wrap(32'(rr_ptr_q) + k)] == StReady) begin
                pick_vld = 1'b1;
                pick_ctx = ctx_wrap(32'(rr_ptr_q) + k);
            end
        end
    end

    assign issue      = pick_vld && !bus.i_xa_stall;
    // Redirect/halt only matter when XA actually moves a valid instruction into CA.
    assign xa_adv     = xa_vld_q && !bus.i_xa_stall;
    assign xa_next_pc = bus.i_xa_redirect_vld ? bus.i_xa_redirect_pc : xa_pc_q + PC_W'(1);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int unsigned i = 0; i < CTX_N; i++) begin
                ctx_st_q[i] <= StIdle;
                ctx_pc_q[i] <= '0;
            end
            rr_ptr_q <= '0;
            fa_occ_q <= 1'b0;
            fa_vld_q <= 1'b0;
            fa_ctx_q <= '0;
            fa_pc_q  <= '0;
            xa_vld_q <= 1'b0;
            xa_ctx_q <= '0;
            xa_pc_q  <= '0;
            ca_vld_q <= 1'b0;
            ca_ctx_q <= '0;
            ca_pc_q  <= '0;
        end else begin
            fa_vld_q <= issue;
            if (!bus.i_xa_stall) begin
                fa_occ_q <= issue;
                xa_vld_q <= fa_occ_q;
                xa_ctx_q <= fa_ctx_q;
                xa_pc_q  <= fa_pc_q;
            end
            if (issue) begin
                fa_ctx_q <= pick_ctx;
                fa_pc_q  <= ctx_pc_q[pick_ctx];
                rr_ptr_q <= ctx_wrap(32'(pick_ctx) + 32'd1);
            end

            ca_vld_q <= xa_adv;
            if (xa_adv) begin
                ca_ctx_q <= xa_ctx_q;
                ca_pc_q  <= xa_pc_q;
            end

            // Start, issue and commit each act on a different state (IDLE, READY,
            // INFLIGHT), so they never collide on one context. A start aimed at a
            // context that is committing to IDLE sees it INFLIGHT and is dropped.
            for (int unsigned i = 0; i < CTX_N; i++) begin
                if (bus.i_start_vld && bus.i_start_ctx == CTX_W'(i) &&
                    ctx_st_q[i] == StIdle) begin
                    ctx_st_q[i] <= StReady;
                    ctx_pc_q[i] <= bus.i_start_pc;
                end
                if (issue && pick_ctx == CTX_W'(i)) begin
                    ctx_st_q[i] <= StInflight;
                end
                if (xa_adv && xa_ctx_q == CTX_W'(i)) begin
                    if (bus.i_xa_halt) begin
                        ctx_st_q[i] <= StIdle;
                    end else begin
                        ctx_st_q[i] <= StReady;
                        ctx_pc_q[i] <= xa_next_pc;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.o_ctx_busy = '0;
        for (int unsigned i = 0; i < CTX_N; i++) begin
            bus.o_ctx_busy[i] = (ctx_st_q[i] != StIdle);
        end
    end

    assign bus.o_fa_vld = fa_vld_q;
    assign bus.o_fa_ctx = fa_ctx_q;
    assign bus.o_fa_pc  = fa_pc_q;
    assign bus.o_ca_vld = ca_vld_q;
    assign bus.o_ca_ctx = ca_ctx_q;
    assign bus.o_ca_pc  = ca_pc_q;

`ifdef ENG_PIPE_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    // Counts on the same edge that raises o_ca_vld, so the value includes the visible commit.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            perf_cnt_q <= '0;
        end else if (xa_adv && perf_cnt_q != 32'hFFFF_FFFF) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign bus.o_perf_commit_cnt = perf_cnt_q;
`else
    assign bus.o_perf_commit_cnt = '0;
`endif
endmodule
